// File: rtl/kbd_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : kbd_input_arbiter
// Purpose  : Merges UART and PS/2 ASCII key bytes into one keyboard stream for
//            the Apple 1 PIA. One holding register per source, round-robin
//            arbitration into a small FIFO, sticky overflow on dropped bytes.
// Revision : 1.0  initial release
// ============================================================================
module kbd_input_arbiter #(
  parameter int FIFO_DEPTH = 8,
  parameter bit UPPERCASE  = 1'b1,
  parameter bit LF_TO_CR   = 1'b1
) (
  input  logic                          clk25,
  input  logic                          rst,
  input  logic                          uart_strobe,
  input  logic [7:0]                    uart_data,
  input  logic                          ps2_strobe,
  input  logic [7:0]                    ps2_data,
  input  logic [1:0]                    src_mode,
  input  logic                          flush,
  input  logic                          kbd_rd,
  output logic [7:0]                    kbd_data,
  output logic                          kbd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);

  // Key byte translation applied before a byte enters its holding register
  function automatic logic [7:0] map_key(input logic [7:0] b);
    map_key = b;
    if (LF_TO_CR && (b == 8'h0A))
      map_key = 8'h0D;
    else if (UPPERCASE && (b >= 8'h61) && (b <= 8'h7A))
      map_key = b - 8'h20;
  endfunction

  // Holding registers, last grant, FIFO storage and state
  logic             r_uart_valid, r_ps2_valid;
  logic [7:0]       r_uart_byte, r_ps2_byte;
  logic             r_last_ps2;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [c_CW-1:0]  r_count;
  logic [7:0]       r_kbd_data;
  logic             r_overflow;

  // Source enables: 00 both, 01 UART only, 10 PS/2 only, 11 none
  logic w_uart_en, w_ps2_en;
  logic w_uart_req, w_ps2_req;
  logic w_pop, w_space;
  logic w_grant_uart, w_grant_ps2, w_push;
  logic [7:0] w_push_data;
  logic w_drop_uart, w_drop_ps2;
  logic [c_AW-1:0] w_rd_next;
  logic [c_CW-1:0] w_cnt_after_pop;
  logic [7:0] w_next_head;

  assign w_uart_en  = ~src_mode[1];
  assign w_ps2_en   = ~src_mode[0];
  // A holding register of a source being disabled is cleared, never forwarded
  assign w_uart_req = r_uart_valid & w_uart_en;
  assign w_ps2_req  = r_ps2_valid  & w_ps2_en;
  assign w_pop      = kbd_rd & (r_count != '0);
  // A push is allowed into a full FIFO when the same cycle pops the head
  assign w_space    = (r_count != c_FULL) | w_pop;

  // Round-robin grant: on a tie the source not granted last time wins
  always_comb begin
    w_grant_uart = 1'b0;
    w_grant_ps2  = 1'b0;
    if (w_space) begin
      if (w_uart_req && w_ps2_req) begin
        if (r_last_ps2) w_grant_uart = 1'b1;
        else            w_grant_ps2  = 1'b1;
      end else if (w_uart_req) begin
        w_grant_uart = 1'b1;
      end else if (w_ps2_req) begin
        w_grant_ps2 = 1'b1;
      end
    end
  end

  assign w_push      = w_grant_uart | w_grant_ps2;
  assign w_push_data = w_grant_uart ? r_uart_byte : r_ps2_byte;
  // A second strobe into an occupied register that is not draining is lost
  assign w_drop_uart = w_uart_en & uart_strobe & r_uart_valid & ~w_grant_uart;
  assign w_drop_ps2  = w_ps2_en  & ps2_strobe  & r_ps2_valid  & ~w_grant_ps2;

  // Head after this edge: the pushed byte if the FIFO would otherwise be empty
  assign w_rd_next       = r_rd_ptr + c_AW'(w_pop);
  assign w_cnt_after_pop = r_count - c_CW'(w_pop);
  always_comb begin
    w_next_head = 8'h80;
    if (w_cnt_after_pop == '0) begin
      if (w_push) w_next_head = {1'b1, w_push_data[6:0]};
    end else begin
      w_next_head = {1'b1, r_mem[w_rd_next][6:0]};
    end
  end

  // UART holding register: load, drain, or clear when the source is disabled
  always_ff @(posedge clk25) begin
    if (rst || flush) begin
      r_uart_valid <= 1'b0;
      r_uart_byte  <= 8'h00;
    end else if (!w_uart_en) begin
      r_uart_valid <= 1'b0;
    end else if (uart_strobe && !w_drop_uart) begin
      r_uart_valid <= 1'b1;
      r_uart_byte  <= map_key(uart_data);
    end else if (w_grant_uart) begin
      r_uart_valid <= 1'b0;
    end
  end

  // PS/2 holding register: load, drain, or clear when the source is disabled
  always_ff @(posedge clk25) begin
    if (rst || flush) begin
      r_ps2_valid <= 1'b0;
      r_ps2_byte  <= 8'h00;
    end else if (!w_ps2_en) begin
      r_ps2_valid <= 1'b0;
    end else if (ps2_strobe && !w_drop_ps2) begin
      r_ps2_valid <= 1'b1;
      r_ps2_byte  <= map_key(ps2_data);
    end else if (w_grant_ps2) begin
      r_ps2_valid <= 1'b0;
    end
  end

  // Last grant survives flush so arbitration fairness carries across it
  always_ff @(posedge clk25) begin
    if (rst)
      r_last_ps2 <= 1'b1;
    else if (!flush && w_push)
      r_last_ps2 <= w_grant_ps2;
  end

  // Sticky overflow flag
  always_ff @(posedge clk25) begin
    if (rst || flush)
      r_overflow <= 1'b0;
    else if (w_drop_uart || w_drop_ps2)
      r_overflow <= 1'b1;
  end

  // FIFO storage write
  always_ff @(posedge clk25) begin
    if (w_push && !rst && !flush)
      r_mem[r_wr_ptr] <= w_push_data;
  end

  // FIFO pointers, occupancy and registered head
  always_ff @(posedge clk25) begin
    if (rst || flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_kbd_data <= 8'h80;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr   <= w_rd_next;
      r_count    <= w_cnt_after_pop + c_CW'(w_push);
      r_kbd_data <= w_next_head;
    end
  end

  assign kbd_data   = r_kbd_data;
  assign kbd_ready  = (r_count != '0);
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire
